// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Lookup is combinational from IF_PC; training happens on the rising edge
// from resolved EX branches. Also flags direction mispredictions and keeps
// saturating prediction statistics.

// One BTB entry: valid/tag/target/counter plus its own update rule.
module bp_entry #(
  parameter int TAG_W = 6,
  parameter int PC_W  = 12
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             upd_i,     // EX update targets this entry's index
  input  logic             taken_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [PC_W-1:0]  target_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [PC_W-1:0]  target_o,
  output logic             pred_o     // counter MSB: predict taken
);
  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [PC_W-1:0]  target_q, target_d;
  logic [1:0]       ctr_q, ctr_d;
  logic             hit;

  assign hit = valid_q && (tag_q == tag_i);

  // Train: hit moves the counter; a taken miss (re)allocates; a not-taken miss is ignored.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_i) begin
      if (hit) begin
        if (taken_i) begin
          ctr_d    = (ctr_q == 2'b11) ? 2'b11 : ctr_q + 2'b01;
          target_d = target_i;
        end else begin
          ctr_d    = (ctr_q == 2'b00) ? 2'b00 : ctr_q - 2'b01;
        end
      end else if (taken_i) begin
        valid_d  = 1'b1;
        tag_d    = tag_i;
        target_d = target_i;
        ctr_d    = 2'b10;
      end
    end
  end

  // Entry state; reset leaves the counter weakly not-taken.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= 2'b01;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  assign valid_o  = valid_q;
  assign tag_o    = tag_q;
  assign target_o = target_q;
  assign pred_o   = ctr_q[1];
endmodule

module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 12
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            IF_VALID,
  input  logic [PC_W-1:0] IF_PC,
  output logic            PRED_TAKEN,
  output logic [PC_W-1:0] PRED_TARGET,
  input  logic            EX_UPD_VALID,
  input  logic [PC_W-1:0] EX_PC,
  input  logic            EX_TAKEN,
  input  logic [PC_W-1:0] EX_TARGET,
  input  logic            EX_PRED_TAKEN,
  output logic            MISPRED,
  output logic [31:0]     PRED_CNT,
  output logic [31:0]     MISPRED_CNT
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;

  logic [ENTRIES-1:0]                 ent_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]      ent_tag;
  logic [ENTRIES-1:0][PC_W-1:0]       ent_target;
  logic [ENTRIES-1:0]                 ent_pred;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit;
  logic             ex_pc_unused;

  assign if_idx = IF_PC[2+IDX_W-1:2];
  assign if_tag = IF_PC[PC_W-1:2+IDX_W];
  assign ex_idx = EX_PC[2+IDX_W-1:2];
  assign ex_tag = EX_PC[PC_W-1:2+IDX_W];
  // Instruction-alignment bits carry no information for indexing or tagging.
  assign ex_pc_unused = ^EX_PC[1:0];

  genvar e;
  generate
    for (e = 0; e < ENTRIES; e++) begin : g_ent
      bp_entry #(.TAG_W(TAG_W), .PC_W(PC_W)) u_ent (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .upd_i    (EX_UPD_VALID && (ex_idx == IDX_W'(e))),
        .taken_i  (EX_TAKEN),
        .tag_i    (ex_tag),
        .target_i (EX_TARGET),
        .valid_o  (ent_valid[e]),
        .tag_o    (ent_tag[e]),
        .target_o (ent_target[e]),
        .pred_o   (ent_pred[e])
      );
    end
  endgenerate

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign if_hit      = ent_valid[if_idx] && (ent_tag[if_idx] == if_tag);
  assign PRED_TAKEN  = IF_VALID && if_hit && ent_pred[if_idx];
  assign PRED_TARGET = PRED_TAKEN ? ent_target[if_idx] : IF_PC + PC_W'(4);

  assign MISPRED = EX_UPD_VALID && (EX_PRED_TAKEN ^ EX_TAKEN);

  logic [31:0] pred_cnt_q, pred_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Statistics counters saturate instead of wrapping.
  always_comb begin
    pred_cnt_d    = pred_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (EX_UPD_VALID) begin
      if (pred_cnt_q != 32'hFFFF_FFFF) pred_cnt_d = pred_cnt_q + 32'd1;
      if (MISPRED && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pred_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pred_cnt_q    <= pred_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign PRED_CNT    = pred_cnt_q;
  assign MISPRED_CNT = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed test-plan points with constant
// expectations plus a randomized phase checked against a reference model.
// Expectations are queued when stimulus is driven and drained at negedge.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int PC_W    = 12;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic            IF_VALID = 1'b0;
  logic [PC_W-1:0] IF_PC = '0;
  logic            PRED_TAKEN;
  logic [PC_W-1:0] PRED_TARGET;
  logic            EX_UPD_VALID = 1'b0;
  logic [PC_W-1:0] EX_PC = '0;
  logic            EX_TAKEN = 1'b0;
  logic [PC_W-1:0] EX_TARGET = '0;
  logic            EX_PRED_TAKEN = 1'b0;
  logic            MISPRED;
  logic [31:0]     PRED_CNT;
  logic [31:0]     MISPRED_CNT;

  branch_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .IF_VALID(IF_VALID), .IF_PC(IF_PC),
    .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
    .EX_UPD_VALID(EX_UPD_VALID), .EX_PC(EX_PC), .EX_TAKEN(EX_TAKEN),
    .EX_TARGET(EX_TARGET), .EX_PRED_TAKEN(EX_PRED_TAKEN), .MISPRED(MISPRED),
    .PRED_CNT(PRED_CNT), .MISPRED_CNT(MISPRED_CNT)
  );

  always #5 CLK = ~CLK;

  // sel: 0 PRED_TAKEN, 1 PRED_TARGET, 2 MISPRED, 3 PRED_CNT, 4 MISPRED_CNT
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];
  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  logic        m_valid [ENTRIES];
  logic [5:0]  m_tag   [ENTRIES];
  logic [11:0] m_tgt   [ENTRIES];
  logic [1:0]  m_ctr   [ENTRIES];
  logic [31:0] m_pc, m_mc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] dut_out(input int sel);
    case (sel)
      0:       return {31'd0, PRED_TAKEN};
      1:       return {20'd0, PRED_TARGET};
      2:       return {31'd0, MISPRED};
      3:       return PRED_CNT;
      default: return MISPRED_CNT;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b01;
    end
    m_pc = 0; m_mc = 0;
  endtask

  // expected outputs for the currently driven inputs, from model state
  task automatic push_model(input string tag);
    int i;
    logic hit, pt;
    i   = int'(IF_PC[5:2]);
    hit = m_valid[i] && (m_tag[i] == IF_PC[11:6]);
    pt  = IF_VALID && hit && m_ctr[i][1];
    push({tag, "_pt"}, 0, {31'd0, pt});
    push({tag, "_tgt"}, 1, {20'd0, pt ? m_tgt[i] : IF_PC + 12'd4});
    push({tag, "_mis"}, 2, {31'd0, EX_UPD_VALID && (EX_PRED_TAKEN != EX_TAKEN)});
    push({tag, "_cnt"}, 3, m_pc);
    push({tag, "_mcnt"}, 4, m_mc);
  endtask

  task automatic m_update();
    int i;
    logic hit;
    if (!EX_UPD_VALID) return;
    i   = int'(EX_PC[5:2]);
    hit = m_valid[i] && (m_tag[i] == EX_PC[11:6]);
    if (hit) begin
      if (EX_TAKEN) begin
        if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'b01;
        m_tgt[i] = EX_TARGET;
      end else if (m_ctr[i] != 2'b00) m_ctr[i] = m_ctr[i] - 2'b01;
    end else if (EX_TAKEN) begin
      m_valid[i] = 1'b1; m_tag[i] = EX_PC[11:6]; m_tgt[i] = EX_TARGET; m_ctr[i] = 2'b10;
    end
    if (m_pc != 32'hFFFF_FFFF) m_pc = m_pc + 1;
    if (EX_PRED_TAKEN != EX_TAKEN && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
  endtask

  task automatic drive(input logic ifv, input logic [11:0] ifpc, input logic upd,
                       input logic [11:0] expc, input logic ext, input logic [11:0] extgt,
                       input logic expred);
    IF_VALID = ifv; IF_PC = ifpc; EX_UPD_VALID = upd; EX_PC = expc;
    EX_TAKEN = ext; EX_TARGET = extgt; EX_PRED_TAKEN = expred;
  endtask

  // queue model expectations, drain the scoreboard at negedge, then clock
  task automatic step(input string tag);
    exp_t e;
    push_model(tag);
    @(negedge CLK);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, dut_out(e.sel), e.exp);
    end
    @(posedge CLK);
    if (RSTn) m_update();
    #1;
  endtask

  initial begin
    logic [11:0] pc, tg;
    m_reset();
    // reset state
    drive(1, 12'h040, 1, 12'h040, 1, 12'h020, 0);
    push("rst_pt", 0, 0); push("rst_tgt", 1, 12'h044); push("rst_mis", 2, 1);
    push("rst_cnt", 3, 0); push("rst_mcnt", 4, 0);
    step("rst");
    step("rst2");
    RSTn = 1'b1;

    // first training: taken miss allocates, mispredicted
    drive(1, 12'h040, 1, 12'h040, 1, 12'h020, 0);
    push("tr1_mis", 2, 1);
    step("tr1");
    drive(1, 12'h040, 0, 12'h000, 0, 12'h000, 0);
    push("tr1_pt", 0, 1); push("tr1_tgt", 1, 12'h020);
    push("tr1_cnt", 3, 1); push("tr1_mcnt", 4, 1);
    step("look1");

    // two not-taken: 10 -> 01 -> 00
    drive(0, 12'h000, 1, 12'h040, 0, 12'h000, 1); step("nt1");
    drive(0, 12'h000, 1, 12'h040, 0, 12'h000, 0); step("nt2");
    drive(1, 12'h040, 0, 12'h000, 0, 12'h000, 0);
    push("nt_pt", 0, 0); push("nt_tgt", 1, 12'h044);
    step("look2");

    // four taken saturate at 11, one not-taken still predicts taken
    for (int k = 0; k < 4; k++) begin
      drive(0, 12'h000, 1, 12'h040, 1, 12'h020, 0); step("tk");
    end
    drive(0, 12'h000, 1, 12'h040, 0, 12'h000, 1); step("nt3");
    drive(1, 12'h040, 0, 12'h000, 0, 12'h000, 0);
    push("sat_pt", 0, 1); push("sat_tgt", 1, 12'h020);
    step("look3");

    // aliasing at index 0
    drive(0, 12'h000, 1, 12'h080, 1, 12'h100, 0); step("al_tr");
    drive(1, 12'h040, 0, 12'h000, 0, 12'h000, 0);
    push("al40_pt", 0, 0); push("al40_tgt", 1, 12'h044);
    step("al40");
    drive(1, 12'h080, 1, 12'h0C0, 0, 12'h000, 0);
    push("al80_pt", 0, 1); push("al80_tgt", 1, 12'h100);
    step("al80");
    drive(1, 12'h080, 0, 12'h000, 0, 12'h000, 0);
    push("alc0_pt", 0, 1); push("alc0_tgt", 1, 12'h100);
    step("alc0");

    // wrap at top of address space
    drive(1, 12'hFFC, 0, 12'h000, 0, 12'h000, 0);
    push("wrap_tgt", 1, 12'h000);
    step("wrap");

    // same-cycle update and lookup: old prediction, new one next cycle
    drive(1, 12'h040, 1, 12'h040, 1, 12'h020, 0);
    push("same_pt", 0, 0); push("same_tgt", 1, 12'h044);
    step("same");
    drive(1, 12'h040, 0, 12'h000, 0, 12'h000, 0);
    push("next_pt", 0, 1); push("next_tgt", 1, 12'h020);
    step("next");

    // randomized traffic over a few colliding PCs
    for (int k = 0; k < 300; k++) begin
      pc = 12'(($urandom_range(1, 3) << 6) | ($urandom_range(0, 3) << 2));
      tg = 12'($urandom_range(0, 1023) << 2);
      drive(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
            12'(($urandom_range(1, 3) << 6) | ($urandom_range(0, 3) << 2)),
            1'($urandom_range(0, 2) != 0), tg, 1'($urandom_range(0, 1)));
      if (k % 37 == 0) IF_PC = 12'hFFC;
      step("rnd");
    end

    // five updates then an asynchronous mid-cycle reset
    for (int k = 0; k < 5; k++) begin
      drive(0, 12'h000, 1, 12'h040, 1, 12'h020, 1); step("pre");
    end
    #2;
    RSTn = 1'b0;
    m_reset();
    drive(1, 12'h040, 1, 12'h040, 1, 12'h020, 1);
    push("mr_pt", 0, 0); push("mr_tgt", 1, 12'h044); push("mr_mis", 2, 0);
    push("mr_cnt", 3, 0); push("mr_mcnt", 4, 0);
    step("mr");
    drive(1, 12'h040, 1, 12'h040, 1, 12'h020, 0);
    push("mr2_mis", 2, 1); push("mr2_cnt", 3, 0); push("mr2_pt", 0, 0);
    step("mr2");
    RSTn = 1'b1;
    drive(1, 12'h040, 1, 12'h040, 1, 12'h020, 0);
    push("post_cnt", 3, 0); push("post_pt", 0, 0);
    step("post");
    drive(1, 12'h040, 0, 12'h000, 0, 12'h000, 0);
    push("post1_cnt", 3, 1); push("post1_mcnt", 4, 1);
    push("post1_pt", 0, 1); push("post1_tgt", 1, 12'h020);
    step("post1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
